aes_key_sched_ctrl: RTL

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_pkg.sv | 30 +++
 rtl/aes_rk_store.sv | 34 +++
 rtl/aes_key_sched_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types for the AES-256 round-key schedule controller.
//
// Contents:
//   AES256_NUM_RK - number of AES-256 round keys (15)
//   RK_IDX_W      - width of a round-key index
//   aes_rk_t      - 128-bit round key
//   aes_key_t     - 256-bit cipher key
//   ks_state_e    - controller FSM state
//
// Optional feature macro: AES_KEYSCHED_ZEROIZE_EN adds the StZero state.
package aes_pkg;

    localparam int unsigned AES256_NUM_RK = 15;
    localparam int unsigned RK_IDX_W      = 4;

    typedef logic [127:0] aes_rk_t;
    typedef logic [255:0] aes_key_t;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StCollect,
        StReady
`ifdef AES_KEYSCHED_ZEROIZE_EN
        ,
        StZero
`endif
    } ks_state_e;

endpackage

// File: rtl/aes_rk_store.sv
// Round-key register file: NUM_RK entries of 128 bits.
//
// Ports:
//   clk    - clock, rising edge
//   we     - write enable
//   waddr  - write index
//   wdata  - write data
//   raddr  - read index
//   rdata  - registered read data (previous contents on a same-cycle write)
//
// Storage has no reset; out-of-range reads return zero.
module aes_rk_store
    import aes_pkg::*;
#(
    parameter int unsigned NUM_RK = AES256_NUM_RK
) (
    input  logic                clk,
    input  logic                we,
    input  logic [RK_IDX_W-1:0] waddr,
    input  logic [127:0]        wdata,
    input  logic [RK_IDX_W-1:0] raddr,
    output logic [127:0]        rdata
);

    aes_rk_t mem [NUM_RK];

    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < NUM_RK)) begin
            mem[waddr] <= wdata;
        end
        rdata <= (32'(raddr) < NUM_RK) ? mem[raddr] : '0;
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-256 key-schedule controller.
//
// Accepts a 256-bit cipher key, kicks an external expansion engine, collects
// its subkey beats into a round-key store, and serves one-cycle-latency
// round-key reads once all keys are present. Stalled engines are aborted
// after TIMEOUT idle cycles.
//
// Ports:
//   clk, reset                   - clock and synchronous active-high reset
//   zeroize                      - (AES_KEYSCHED_ZEROIZE_EN only) wipe storage
//   key_load_valid/ready, key_in - cipher key handshake
//   exp_start, exp_key           - engine start pulse and key
//   exp_valid, exp_subkey        - engine subkey beats
//   rk_req, rk_idx               - round-key read request
//   rk_valid, rk_data, rk_err    - read response / error pulse
//   keys_ready, busy             - status
//
// Optional feature macro: AES_KEYSCHED_ZEROIZE_EN.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NUM_RK  = AES256_NUM_RK,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                reset,
`ifdef AES_KEYSCHED_ZEROIZE_EN
    input  logic                zeroize,
`endif
    input  logic                key_load_valid,
    output logic                key_load_ready,
    input  logic [255:0]        key_in,
    output logic                exp_start,
    output logic [255:0]        exp_key,
    input  logic                exp_valid,
    input  logic [127:0]        exp_subkey,
    input  logic                rk_req,
    input  logic [RK_IDX_W-1:0] rk_idx,
    output logic                rk_valid,
    output logic [127:0]        rk_data,
    output logic                rk_err,
    output logic                keys_ready,
    output logic                busy
);

    localparam int unsigned ToW = $clog2(TIMEOUT + 1);
    // Counter holds (idle cycles - 1); firing here puts rk_err exactly
    // TIMEOUT cycles after the last beat.
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 2);

    ks_state_e           state_q;
    logic [RK_IDX_W-1:0] cnt_q;
    logic [ToW-1:0]      to_cnt_q;
`ifdef AES_KEYSCHED_ZEROIZE_EN
    logic [RK_IDX_W-1:0] zcnt_q;
`endif

    logic                idle_or_ready;
    logic                accept;
    logic                rd_ok;
    logic                rd_bad;
    logic                st_we;
    logic [RK_IDX_W-1:0] st_waddr;
    logic [127:0]        st_wdata;
    logic [127:0]        st_rdata;

    assign idle_or_ready  = (state_q == StIdle) || (state_q == StReady);
`ifdef AES_KEYSCHED_ZEROIZE_EN
    assign accept         = idle_or_ready && key_load_valid && !zeroize;
`else
    assign accept         = idle_or_ready && key_load_valid;
`endif
    assign key_load_ready = idle_or_ready;
    assign busy           = !idle_or_ready;
    assign exp_start      = (state_q == StStart);

    assign rd_ok  = rk_req && keys_ready && (32'(rk_idx) < NUM_RK);
    assign rd_bad = rk_req && !rd_ok;

    assign rk_data = rk_valid ? st_rdata : '0;

    // Single write port: entry 0 on acceptance, entry 1 during START from the
    // latched key, then engine beats; reset blocks every write.
    always_comb begin
        st_we    = 1'b0;
        st_waddr = '0;
        st_wdata = '0;
        if (!reset) begin
`ifdef AES_KEYSCHED_ZEROIZE_EN
            if (state_q == StZero) begin
                st_we    = 1'b1;
                st_waddr = zcnt_q;
            end else if (zeroize) begin
                st_we    = 1'b0;
            end else
`endif
            if (accept) begin
                st_we    = 1'b1;
                st_waddr = RK_IDX_W'(0);
                st_wdata = key_in[255:128];
            end else if (state_q == StStart) begin
                st_we    = 1'b1;
                st_waddr = RK_IDX_W'(1);
                st_wdata = exp_key[127:0];
            end else if ((state_q == StCollect) && exp_valid) begin
                st_we    = 1'b1;
                st_waddr = cnt_q;
                st_wdata = exp_subkey;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= RK_IDX_W'(2);
            to_cnt_q   <= '0;
            exp_key    <= '0;
            rk_valid   <= 1'b0;
            rk_err     <= 1'b0;
            keys_ready <= 1'b0;
`ifdef AES_KEYSCHED_ZEROIZE_EN
            zcnt_q     <= '0;
`endif
        end else begin
            rk_valid <= rd_ok;
            rk_err   <= rd_bad;
`ifdef AES_KEYSCHED_ZEROIZE_EN
            if (zeroize) begin
                state_q    <= StZero;
                zcnt_q     <= '0;
                keys_ready <= 1'b0;
            end else
`endif
            begin
                unique case (state_q)
                    StIdle, StReady: begin
                        if (accept) begin
                            state_q    <= StStart;
                            keys_ready <= 1'b0;
                            exp_key    <= key_in;
                        end
                    end
                    StStart: begin
                        state_q  <= StCollect;
                        cnt_q    <= RK_IDX_W'(2);
                        to_cnt_q <= '0;
                    end
                    StCollect: begin
                        if (exp_valid) begin
                            to_cnt_q <= '0;
                            cnt_q    <= cnt_q + RK_IDX_W'(1);
                            if (32'(cnt_q) == NUM_RK - 1) begin
                                state_q    <= StReady;
                                keys_ready <= 1'b1;
                            end
                        end else if (to_cnt_q == ToLast) begin
                            rk_err  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            to_cnt_q <= to_cnt_q + ToW'(1);
                        end
                    end
`ifdef AES_KEYSCHED_ZEROIZE_EN
                    StZero: begin
                        if (32'(zcnt_q) == NUM_RK - 1) begin
                            state_q <= StIdle;
                        end else begin
                            zcnt_q <= zcnt_q + RK_IDX_W'(1);
                        end
                    end
`endif
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    aes_rk_store #(
        .NUM_RK (NUM_RK)
    ) u_store (
        .clk   (clk),
        .we    (st_we),
        .waddr (st_waddr),
        .wdata (st_wdata),
        .raddr (rk_idx),
        .rdata (st_rdata)
    );

endmodule
